// File: rtl/matmul_seq_ctrl.sv
// Sequential 4x4 matrix multiply controller: loads A and B row-major, runs one shared
// MAC unit over (i, j, k) for 64 issue cycles, then streams C row-major.
// The product is registered before accumulation, so the final C element lands one cycle
// after the last issue; that same edge enters DRAIN.
module matmul_seq_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ProdW = 2 * DATA_W;

  typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StCompute, StDrain} state_e;

  state_e r_state;

  logic [3:0] r_idx;
  logic [3:0] r_oidx;
  logic [1:0] r_i, r_j, r_k;
  logic       r_issue;

  logic [DATA_W-1:0] r_a [16];
  logic [DATA_W-1:0] r_b [16];
  logic [DATA_W-1:0] r_c [16];

  // Product pipeline stage carries the loop position alongside the product.
  logic [ProdW-1:0] r_prod;
  logic             r_p_vld;
  logic             r_p_k0;
  logic             r_p_k3;
  logic             r_p_end;
  logic [3:0]       r_p_cidx;
  logic [ACC_W-1:0] r_acc;

  logic r_in_ready, r_out_valid, r_out_last, r_busy, r_done;

  logic [3:0]       w_a_idx, w_b_idx;
  logic [ProdW-1:0] w_a_ext, w_b_ext, w_prod;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_in_acc, w_out_acc;

  assign w_a_idx    = {r_i, r_k};
  assign w_b_idx    = {r_k, r_j};
  assign w_a_ext    = {{DATA_W{1'b0}}, r_a[w_a_idx]};
  assign w_b_ext    = {{DATA_W{1'b0}}, r_b[w_b_idx]};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_acc_next = r_p_k0 ? ACC_W'(r_prod) : r_acc + ACC_W'(r_prod);
  assign w_in_acc   = r_in_ready && in_valid;
  assign w_out_acc  = r_out_valid && out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_c[r_oidx];
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

  // Control FSM: state, loop counters and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_oidx      <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_issue     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state    <= StLoadA;
            r_idx      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        StLoadA: begin
          if (w_in_acc) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == 4'd15) r_state <= StLoadB;
          end
        end
        StLoadB: begin
          if (w_in_acc) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == 4'd15) begin
              r_state    <= StCompute;
              r_in_ready <= 1'b0;
              r_i        <= '0;
              r_j        <= '0;
              r_k        <= '0;
              r_issue    <= 1'b1;
            end
          end
        end
        StCompute: begin
          if (r_issue) begin
            // k is the least significant field, so it runs fastest.
            {r_i, r_j, r_k} <= {r_i, r_j, r_k} + 6'd1;
            if ({r_i, r_j, r_k} == 6'h3f) r_issue <= 1'b0;
          end
          if (r_p_vld && r_p_end) begin
            r_state     <= StDrain;
            r_oidx      <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
          end
        end
        StDrain: begin
          if (w_out_acc) begin
            r_oidx     <= r_oidx + 4'd1;
            r_out_last <= (r_oidx == 4'd14);
            if (r_oidx == 4'd15) begin
              r_state     <= StIdle;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Operand storage: written only by accepted input words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 16; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
      end
    end else if (w_in_acc) begin
      if (r_state == StLoadA) r_a[r_idx] <= in_data;
      if (r_state == StLoadB) r_b[r_idx] <= in_data;
    end
  end

  // MAC pipeline: register the product, then accumulate and retire C on k == 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod   <= '0;
      r_p_vld  <= 1'b0;
      r_p_k0   <= 1'b0;
      r_p_k3   <= 1'b0;
      r_p_end  <= 1'b0;
      r_p_cidx <= '0;
      r_acc    <= '0;
      for (int n = 0; n < 16; n++) r_c[n] <= '0;
    end else begin
      r_p_vld  <= (r_state == StCompute) && r_issue;
      r_prod   <= w_prod;
      r_p_k0   <= (r_k == 2'd0);
      r_p_k3   <= (r_k == 2'd3);
      r_p_end  <= ({r_i, r_j, r_k} == 6'h3f);
      r_p_cidx <= {r_i, r_j};
      if (r_p_vld) begin
        r_acc <= w_acc_next;
        if (r_p_k3) r_c[r_p_cidx] <= w_acc_next[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: table of whole-job vectors plus hand-written abort and
// start/in_valid poke sequences. Expected C words are queued when a job is loaded.
module tb_matmul_seq_ctrl;

  localparam int DW = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_valid, out_last, out_ready, busy, done;
  logic [DW-1:0] in_data, out_data;

  matmul_seq_ctrl #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ma [16];
  logic [DW-1:0] mb [16];
  logic [DW-1:0] got [16];
  logic [DW-1:0] exp_q [$];

  typedef struct {
    string       name;
    int          kind;
    int          in_gap;
    int          rdy_low;
    bit          chk_lat;
    bit          chk_const;
    logic [15:0] c0;
    logic [15:0] c5;
    logic [15:0] c15;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference matrix product with accumulator wrap, truncated to the element width.
  function automatic void push_expected();
    logic [AW-1:0] acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc + AW'(ma[i*4+k]) * AW'(mb[k*4+j]);
        exp_q.push_back(acc[DW-1:0]);
      end
    end
  endfunction

  task automatic fill(input int kind);
    for (int n = 0; n < 16; n++) begin
      case (kind)
        0: begin ma[n] = (n % 5 == 0) ? 16'd1 : 16'd0; mb[n] = DW'(n); end
        1: begin ma[n] = DW'(n + 1); mb[n] = DW'(n + 1); end
        2: begin ma[n] = 16'hffff; mb[n] = 16'hffff; end
        default: begin ma[n] = DW'($urandom); mb[n] = DW'($urandom); end
      endcase
    end
  endtask

  task automatic run_job(input int in_gap, input int rdy_low, input bit chk_lat, input bit poke,
                         input int abort_at);
    int w, t_last, guard, nacc, ndone;
    logic [DW-1:0] held, e;
    bit hold_pend, leak;
    t_last = 0;
    if (abort_at == 0) push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    guard = 0;
    while (w < 32 && guard < 2000) begin
      in_valid = ($urandom_range(99) >= in_gap);
      in_data  = (w < 16) ? ma[w] : mb[w-16];
      start    = (poke && w >= 16) ? ($urandom_range(3) == 0) : 1'b0;
      if (in_valid && in_ready) begin
        w++;
        t_last = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (w < 32) begin
      check("load_timeout", w, 32);
      exp_q.delete();
      return;
    end
    check("busy_compute", busy, 1'b1);
    guard = 0;
    leak  = 1'b0;
    while (!out_valid && guard < 200) begin
      if (abort_at != 0 && guard == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_last", out_last, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_out_data", out_data, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 1'b0);
        exp_q.delete();
        return;
      end
      if (poke) begin
        in_valid = 1'($urandom_range(1));
        in_data  = 16'hdead;
        start    = 1'($urandom_range(1));
        if (in_ready) leak = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1'b1);
      exp_q.delete();
      return;
    end
    if (chk_lat) check("latency", cyc - t_last, 65);
    if (poke) check("in_ready_compute", leak, 1'b0);
    nacc = 0;
    ndone = 0;
    guard = 0;
    hold_pend = 1'b0;
    held = '0;
    while (nacc < 16 && guard < 500) begin
      out_ready = ($urandom_range(99) >= rdy_low);
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      if (done) ndone++;
      if (hold_pend) check("hold_data", out_data, held);
      hold_pend = 1'b0;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("c_data", out_data, e);
        check("c_last", out_last, (nacc == 15));
        got[nacc] = out_data;
        nacc++;
      end else if (out_valid) begin
        held = out_data;
        hold_pend = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (nacc < 16) begin
      check("drain_timeout", nacc, 16);
      exp_q.delete();
      return;
    end
    check("done_early", ndone, 0);
    check("done_pulse", done, 1'b1);
    check("busy_with_done", busy, 1'b0);
    check("out_valid_after", out_valid, 1'b0);
    @(negedge clk);
    check("done_clear", done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"identity_ramp", 0, 0, 0, 1'b0, 1'b1, 16'd0, 16'd5, 16'd15};
    vecs[1] = '{"n_plus_1", 1, 0, 0, 1'b1, 1'b1, 16'd90, 16'd228, 16'd600};
    vecs[2] = '{"all_ffff", 2, 0, 0, 1'b0, 1'b1, 16'h4, 16'h4, 16'h4};
    vecs[3] = '{"n_plus_1_gaps", 1, 50, 30, 1'b0, 1'b1, 16'd90, 16'd228, 16'd600};
    vecs[4] = '{"random_gaps", 3, 50, 30, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    rst = 1'b0;

    // Input words without a start must not open the load port.
    in_valid = 1'b1;
    in_data = 16'hbeef;
    repeat (3) @(negedge clk);
    check("idle_in_ready", in_ready, 1'b0);
    check("idle_busy", busy, 1'b0);
    in_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].kind);
      run_job(vecs[v].in_gap, vecs[v].rdy_low, vecs[v].chk_lat, 1'b0, 0);
      if (vecs[v].chk_const) begin
        check({vecs[v].name, "_c0"}, got[0], vecs[v].c0);
        check({vecs[v].name, "_c5"}, got[5], vecs[v].c5);
        check({vecs[v].name, "_c15"}, got[15], vecs[v].c15);
      end
    end

    // Reset during COMPUTE, then a full reload.
    fill(3);
    run_job(0, 0, 1'b0, 1'b0, 30);
    fill(3);
    run_job(20, 20, 1'b0, 1'b0, 0);

    // Stray start and in_valid outside IDLE/LOAD, then a clean job.
    fill(1);
    run_job(30, 30, 1'b0, 1'b1, 0);
    fill(3);
    run_job(0, 0, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequential controller for a 4x4 matrix multiply C = A x B. It streams in A and B row-major over a valid/ready input, and sequences one shared multiply-accumulate (MAC) unit over (i, j, k) loop counters for 64 cycles. It then streams out C row-major over a valid/ready output. It replaces the fully unrolled 16-multiplier array wherever area matters more than latency.

Parameters:
DATA_W, 16, element width of A, B and C
ACC_W, 32, accumulator width; must be >= 2*DATA_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high; clears all state
start  input  1  single-cycle pulse; begins a job; honoured only in IDLE
in_valid  input  1  input word valid
in_data  input  DATA_W  A[0..15] then B[0..15], row-major
in_ready  output  1  high in LOAD_A and LOAD_B
out_valid  output  1  C word valid
out_data  output  DATA_W  C element, row-major
out_last  output  1  high with C[15]
out_ready  input  1  downstream accepts the C word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when C[15] is accepted

Behaviour:
- Reset (async assert, then sync deassert by clk):
  - state = IDLE.
  - All counters, accumulator, A/B/C storage = 0.
  - in_ready = out_valid = out_last = busy = done = 0.
- States: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> DRAIN -> IDLE.
- IDLE:
  - start = 1 -> LOAD_A, load index = 0.
  - start is ignored in every other state.
- LOAD_A / LOAD_B:
  - A word is accepted on in_valid && in_ready; it is written to A[idx] or B[idx] and idx increments.
  - idx wraps 15 -> 0.
  - The 16th A accept moves to LOAD_B; the 16th B accept moves to COMPUTE with i = j = k = 0.
  - in_valid = 0 stalls the load with no timeout.
- COMPUTE: exactly 64 cycles, one MAC per cycle.
  - Each cycle: prod = A[i*4+k] * B[k*4+j], unsigned, full 2*DATA_W.
  - k = 0: acc <= prod.
  - k = 1..3: acc <= acc + prod.
  - acc wraps modulo 2^ACC_W.
  - k = 3 cycle: C[i*4+j] <= low DATA_W bits of (acc + prod). C is the truncated sum; no saturation.
  - Counter order: k fastest, then j, then i.
  - Cycle with i = j = k = 3 -> DRAIN, out index = 0.
  - in_ready = 0 throughout.
- Latency: last B accepted at edge t -> first out_valid high after edge t+65 (64 compute cycles, then registered DRAIN entry).
- DRAIN:
  - out_valid = 1; out_data = C[oidx] (registered array, combinational read); out_last = (oidx == 15).
  - oidx advances only on out_valid && out_ready.
  - out_ready held low: out_data and out_last stay stable.
  - Accept of oidx 15: done = 1 for that single following cycle, state -> IDLE.
- A, B and C storage persist after a job until they are overwritten; they are not cleared between jobs.
- Reset asserted in any state aborts the job immediately. Partial data is discarded; the next start begins from A[0].
- Inputs presented while out of LOAD states are ignored; no data is consumed.

Test Plan:
- A = identity (diag 1), B[n] = n for n = 0..15 -> C streams 0..15 in order; out_last only on the 16th word; done pulses once; busy falls the same cycle as done.
- A[n] = B[n] = n+1 -> C row 0 = 90, 100, 110, 120; C[15] = 600; first out_valid exactly 65 cycles after the last B accept.
- All A, B = 0xFFFF -> every C word = 0x0004, exercising truncation and accumulator wrap.
- Random in_valid gaps (about 50%) and out_ready toggling (about 30% low) -> same C values as a gap-free run; out_data held stable while out_ready = 0; no word lost or duplicated.
- Reset pulse at COMPUTE cycle 30 -> all outputs 0 and state IDLE. A new start with a full reload then yields correct results.
- start pulsed during LOAD_B, COMPUTE and DRAIN -> no effect on that job. in_valid driven during COMPUTE -> in_ready stays 0 and the next job's A[0] is the first word after the next start.
